// File: rtl/ysyx_25040101_imm_unit.sv
// Immediate extraction unit with a 2-entry result FIFO and a valid/ready handshake on both sides.
// Optional macro YSYX_25040101_IMM_ERR_EN adds err_o, flagging RV32 shift amounts with inst[25] set.
module ysyx_25040101_imm_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:7]       inst_i,
  input  logic [2:0]        imm_src_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   imm_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [2:0]        src_o
`ifdef YSYX_25040101_IMM_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic [2:0]       src;
`ifdef YSYX_25040101_IMM_ERR_EN
    logic             err;
`endif
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  logic [CNT_W-1:0] count;
  logic             wptr;
  logic             rptr;
  logic             push;
  logic             pop;
  logic [31:0]      raw32;
  logic             is_sext;
  logic [5:0]       shamt;

  assign in_ready  = rst_n && (count != CNT_W'(DEPTH));
  // Held low during reset so no output transfer can happen in the reset cycle.
  assign out_valid = rst_n && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Immediate decode: build a 32-bit pattern, then sign- or zero-extend to XLEN.
  always_comb begin
    raw32     = '0;
    is_sext   = 1'b0;
    new_entry = '0;
    shamt     = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};
    case (imm_src_i)
      3'b001: begin
        raw32   = {{20{inst_i[31]}}, inst_i[31:20]};
        is_sext = 1'b1;
      end
      3'b010: begin
        raw32   = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        is_sext = 1'b1;
      end
      3'b011: begin
        raw32   = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        is_sext = 1'b1;
      end
      3'b100: begin
        raw32   = {inst_i[31:12], 12'b0};
        is_sext = 1'b1;
      end
      3'b101: begin
        raw32   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        is_sext = 1'b1;
      end
      3'b110:  raw32 = 32'(inst_i[19:15]);
      3'b111:  raw32 = 32'(shamt);
      default: raw32 = '0;
    endcase
    if (is_sext) new_entry.imm = XLEN'($signed(raw32));
    else         new_entry.imm = XLEN'(raw32);
    new_entry.tag = tag_i;
    new_entry.src = imm_src_i;
`ifdef YSYX_25040101_IMM_ERR_EN
    new_entry.err = (imm_src_i == 3'b111) && (XLEN == 32) && inst_i[25];
`endif
  end

  // FIFO state; storage is cleared on reset so the outputs read back as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= new_entry;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign imm_o = mem[rptr].imm;
  assign tag_o = mem[rptr].tag;
  assign src_o = mem[rptr].src;
`ifdef YSYX_25040101_IMM_ERR_EN
  assign err_o = mem[rptr].err;
`endif

endmodule

// File: tb/tb_ysyx_25040101_imm_unit.sv
// Directed bench: an RV32 and an RV64 instance share stimulus; results checked with immediate assertions.
module tb_ysyx_25040101_imm_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:7] inst_i;
  logic [2:0]  imm_src_i;
  logic [31:0] tag_i;

  logic        in_ready32, in_ready64, out_valid32, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [31:0] tag32, tag64;
  logic [2:0]  src32, src64;
`ifdef YSYX_25040101_IMM_ERR_EN
  logic        err32, err64;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_25040101_imm_unit #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .inst_i(inst_i), .imm_src_i(imm_src_i), .tag_i(tag_i),
    .out_valid(out_valid32), .out_ready(out_ready),
    .imm_o(imm32), .tag_o(tag32), .src_o(src32)
`ifdef YSYX_25040101_IMM_ERR_EN
    , .err_o(err32)
`endif
  );

  ysyx_25040101_imm_unit #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .inst_i(inst_i), .imm_src_i(imm_src_i), .tag_i(tag_i),
    .out_valid(out_valid64), .out_ready(out_ready),
    .imm_o(imm64), .tag_o(tag64), .src_o(src64)
`ifdef YSYX_25040101_IMM_ERR_EN
    , .err_o(err64)
`endif
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction through an empty unit with out_ready high: visible after one edge, gone after the next.
  task automatic imm_case(input string name, input logic [31:0] inst, input logic [2:0] code,
                          input logic [31:0] e32, input logic [63:0] e64, input logic eerr32);
    inst_i    = inst[31:7];
    imm_src_i = code;
    tag_i     = 32'h100 + 32'(code);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({name, "_valid32"}, 64'(out_valid32), 64'd1);
    check({name, "_valid64"}, 64'(out_valid64), 64'd1);
    check({name, "_imm32"}, 64'(imm32), 64'(e32));
    check({name, "_imm64"}, imm64, e64);
    check({name, "_src"}, 64'(src32), 64'(code));
    check({name, "_tag"}, 64'(tag64), 64'h100 + 64'(code));
`ifdef YSYX_25040101_IMM_ERR_EN
    check({name, "_err32"}, 64'(err32), 64'(eerr32));
    check({name, "_err64"}, 64'(err64), 64'd0);
`else
    if (eerr32) check({name, "_imm32_trunc"}, 64'(imm32), 64'(e32));
`endif
    tick();
    check({name, "_drained"}, 64'(out_valid32), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst_i    = '0;
    imm_src_i = '0;
    tag_i     = '0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready32), 64'd0);
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_imm", imm64, 64'd0);
    check("rst_tag", 64'(tag32), 64'd0);
    check("rst_src", 64'(src32), 64'd0);
`ifdef YSYX_25040101_IMM_ERR_EN
    check("rst_err", 64'(err32), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready32", 64'(in_ready32), 64'd1);
    check("post_rst_in_ready64", 64'(in_ready64), 64'd1);

    // Immediate formats
    imm_case("i_neg",    32'hFFF0_0000, 3'b001, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    imm_case("b_neg",    32'h8000_0200, 3'b011, 32'hFFFF_F004, 64'hFFFF_FFFF_FFFF_F004, 1'b0);
    imm_case("s_pos",    32'h2400_0280, 3'b010, 32'h0000_0245, 64'h0000_0000_0000_0245, 1'b0);
    imm_case("u_pos",    32'h1234_5080, 3'b100, 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
    imm_case("u_neg",    32'hABCD_E000, 3'b100, 32'hABCD_E000, 64'hFFFF_FFFF_ABCD_E000, 1'b0);
    imm_case("j_neg",    32'hFFFF_F000, 3'b101, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    imm_case("j_pos",    32'h0030_0000, 3'b101, 32'h0000_0802, 64'h0000_0000_0000_0802, 1'b0);
    imm_case("z_zext",   32'h800F_8000, 3'b110, 32'h0000_001F, 64'h0000_0000_0000_001F, 1'b0);
    imm_case("shamt_hi", 32'h0250_0000, 3'b111, 32'h0000_0005, 64'h0000_0000_0000_0025, 1'b1);
    imm_case("shamt_lo", 32'h0050_0000, 3'b111, 32'h0000_0005, 64'h0000_0000_0000_0005, 1'b0);
    imm_case("zero",     32'hFFFF_FFFF, 3'b000, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b0);

    // Backpressure: three pushes with out_ready low
    inst_i    = '0;
    imm_src_i = 3'b000;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tag_i     = 32'd1;
    tick();
    check("bp_tag_after1", 64'(tag32), 64'd1);
    check("bp_ready_after1", 64'(in_ready32), 64'd1);
    tag_i = 32'd2;
    tick();
    check("bp_ready_full", 64'(in_ready32), 64'd0);
    check("bp_tag_hold2", 64'(tag32), 64'd1);
    tag_i = 32'd3;
    tick();
    check("bp_ready_still_full", 64'(in_ready64), 64'd0);
    check("bp_tag_hold3", 64'(tag64), 64'd1);
    check("bp_valid_hold", 64'(out_valid32), 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_pop1_tag", 64'(tag32), 64'd2);
    check("bp_pop1_ready", 64'(in_ready32), 64'd1);
    tick();
    check("bp_pop2_tag", 64'(tag32), 64'd3);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(out_valid32), 64'd0);

    // Steady push+pop at count 1
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tag_i     = 32'd100;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tag_i = 32'd101 + 32'(i);
      tick();
      check("pp_valid", 64'(out_valid32), 64'd1);
      check("pp_tag", 64'(tag32), 64'd101 + 64'(i));
    end
    in_valid = 1'b0;
    tick();
    check("pp_drain", 64'(out_valid64), 64'd0);

    // Reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tag_i     = 32'h55;
    tick();
    tag_i = 32'h66;
    tick();
    check("mr_full", 64'(in_ready32), 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("mr_valid_in_rst", 64'(out_valid32), 64'd0);
    check("mr_ready_in_rst", 64'(in_ready32), 64'd0);
    rst_n = 1'b1;
    #1;
    check("mr_ready_after", 64'(in_ready32), 64'd1);
    check("mr_tag_cleared", 64'(tag32), 64'd0);
    out_ready = 1'b1;
    tick();
    check("mr_no_stale", 64'(out_valid32), 64'd0);
    in_valid = 1'b1;
    tag_i    = 32'h77;
    tick();
    in_valid = 1'b0;
    check("mr_new_tag", 64'(tag32), 64'h77);
    tick();
    check("mr_final_empty", 64'(out_valid32), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
